// File: rtl/ui_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ui_pkg
// Desc   : Shared button FSM states and Hz/ms-to-cycle helpers for UI conditioning.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package ui_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int unsigned db_cyc(input int unsigned clk_hz, input int unsigned debounce_ms);
    return ms_to_cyc(clk_hz, debounce_ms);
  endfunction

  function automatic int unsigned long_cyc(input int unsigned clk_hz, input int unsigned long_ms);
    return ms_to_cyc(clk_hz, long_ms);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : btn_debounce_fsm
// Desc   : One button: 2-flop synchronizer, debounce FSM, press/release/long pulses.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module btn_debounce_fsm
  import ui_pkg::*;
#(
  parameter int unsigned DB_CYC   = 4,
  parameter int unsigned LONG_CYC = 20,
  parameter int unsigned CNT_W    = $clog2(LONG_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic [1:0] c_IDLE         = IDLE;
  localparam logic [1:0] c_PRESS_WAIT   = PRESS_WAIT;
  localparam logic [1:0] c_PRESSED      = PRESSED;
  localparam logic [1:0] c_RELEASE_WAIT = RELEASE_WAIT;

  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DB_CYC - 1);
  // Long fires on the edge the count reaches LONG_CYC-1, so the register lines up with it.
  localparam logic [CNT_W-1:0] c_LONG_PRE = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] c_LONG_SAT = CNT_W'(LONG_CYC);

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_s) begin
            r_state <= c_PRESS_WAIT;
            r_cnt   <= c_ONE;
          end
        end
        c_PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state <= c_PRESSED;
            r_cnt   <= '0;
            o_press <= 1'b1;
            o_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        c_PRESSED: begin
          if (!w_s) begin
            r_state <= c_RELEASE_WAIT;
            r_cnt   <= c_ONE;
          end else if (r_cnt < c_LONG_SAT) begin
            r_cnt <= r_cnt + c_ONE;
            if (r_cnt == c_LONG_PRE) begin
              o_long <= 1'b1;
            end
          end
        end
        c_RELEASE_WAIT: begin
          // Bounce back to high resumes the press with the long count spent.
          if (w_s) begin
            r_state <= c_PRESSED;
            r_cnt   <= c_LONG_SAT;
          end else if (r_cnt == c_DB_LAST) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            o_release <= 1'b1;
            o_level   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_sw_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : btn_sw_conditioner
// Desc   : Synchronizes and debounces board buttons and switches for the controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module btn_sw_conditioner
  import ui_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned N_BTN       = 5,
  parameter int unsigned N_SW        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [N_SW-1:0]  i_sw_raw,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic [N_BTN-1:0] o_btn_long,
  output logic [N_SW-1:0]  o_sw,
  output logic             o_sw_changed
);

  localparam int unsigned c_DB_CYC   = db_cyc(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned c_LONG_CYC = long_cyc(CLK_FREQ, LONG_MS);
  localparam int unsigned c_CNT_W    = $clog2(c_LONG_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(c_DB_CYC - 1);

  if (c_LONG_CYC <= c_DB_CYC) begin : g_bad_timing
    $error("btn_sw_conditioner: LONG_MS must give more cycles than DEBOUNCE_MS");
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_debounce_fsm #(
      .DB_CYC  (c_DB_CYC),
      .LONG_CYC(c_LONG_CYC),
      .CNT_W   (c_CNT_W)
    ) u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (i_btn_raw[gi]),
      .o_level  (o_btn_level[gi]),
      .o_press  (o_btn_press[gi]),
      .o_release(o_btn_release[gi]),
      .o_long   (o_btn_long[gi])
    );
  end

  logic [N_SW-1:0]    r_sw_meta;
  logic [N_SW-1:0]    r_sw_sync;
  logic [N_SW-1:0]    r_sw_cand;
  logic [c_CNT_W-1:0] r_sw_cnt;

  // One counter for the whole bus: any new differing value restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
      r_sw_cand    <= '0;
      r_sw_cnt     <= '0;
      o_sw         <= '0;
      o_sw_changed <= 1'b0;
    end else begin
      r_sw_meta    <= i_sw_raw;
      r_sw_sync    <= r_sw_meta;
      o_sw_changed <= 1'b0;
      if (r_sw_sync == o_sw) begin
        r_sw_cnt <= '0;
      end else if ((r_sw_cnt == '0) || (r_sw_sync != r_sw_cand)) begin
        r_sw_cand <= r_sw_sync;
        r_sw_cnt  <= c_ONE;
      end else if (r_sw_cnt == c_DB_LAST) begin
        o_sw         <= r_sw_sync;
        o_sw_changed <= 1'b1;
        r_sw_cnt     <= '0;
      end else begin
        r_sw_cnt <= r_sw_cnt + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_sw_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_btn_sw_conditioner
// Desc   : Scoreboard bench with a run-length reference model, directed and random stimulus.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_btn_sw_conditioner;

  localparam int N_BTN = 5;
  localparam int N_SW  = 8;
  localparam int DB    = 4;
  localparam int LNG   = 20;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic [N_BTN-1:0] btn_raw = '0;
  logic [N_SW-1:0]  sw_raw  = '0;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_long;
  logic [N_SW-1:0]  sw_out;
  logic             sw_changed;

  btn_sw_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .N_BTN(N_BTN), .N_SW(N_SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_raw), .i_sw_raw(sw_raw),
    .o_btn_level(btn_level), .o_btn_press(btn_press), .o_btn_release(btn_release),
    .o_btn_long(btn_long), .o_sw(sw_out), .o_sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_BTN-1:0] lvl;
    logic [N_BTN-1:0] prs;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] lng;
    logic [N_SW-1:0]  sw;
    logic             chg;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int press_cnt[N_BTN] = '{default: 0};
  int press_cyc[N_BTN] = '{default: 0};
  int rel_cnt[N_BTN]   = '{default: 0};
  int rel_cyc[N_BTN]   = '{default: 0};
  int long_cnt[N_BTN]  = '{default: 0};
  int long_cyc[N_BTN]  = '{default: 0};
  int chg_cnt = 0;
  int chg_cyc = 0;

  // Reference model: a level flips once the sampled input has disagreed with it
  // for DB consecutive samples; sampled input is the raw pin two edges earlier.
  logic [N_BTN-1:0] m_b1 = '0, m_b2 = '0, m_lvl = '0, m_long_ok = '0;
  int               m_run[N_BTN]  = '{default: 0};
  int               m_hold[N_BTN] = '{default: 0};
  logic [N_SW-1:0]  m_s1 = '0, m_s2 = '0, m_sw = '0, m_sw_last = '0;
  int               m_sw_run = 0;

  initial forever begin
    obs_t             e;
    logic [N_BTN-1:0] bs;
    logic [N_SW-1:0]  ss;
    @(posedge clk);
    e = '0;
    cyc++;
    if (!rst_n) begin
      m_b1 = '0; m_b2 = '0; m_lvl = '0; m_long_ok = '0;
      m_s1 = '0; m_s2 = '0; m_sw = '0; m_sw_last = '0; m_sw_run = 0;
      for (int b = 0; b < N_BTN; b++) begin
        m_run[b]  = 0;
        m_hold[b] = 0;
      end
    end else begin
      bs = m_b2; m_b2 = m_b1; m_b1 = btn_raw;
      ss = m_s2; m_s2 = m_s1; m_s1 = sw_raw;
      for (int b = 0; b < N_BTN; b++) begin
        if (m_lvl[b]) begin
          if (bs[b]) begin
            m_hold[b]++;
            if (m_long_ok[b] && m_hold[b] == LNG - 1) begin
              e.lng[b]     = 1'b1;
              m_long_ok[b] = 1'b0;
            end
          end else begin
            m_long_ok[b] = 1'b0;
          end
        end
        if (bs[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_run[b] = 0;
            m_lvl[b] = bs[b];
            if (bs[b]) begin
              e.prs[b]     = 1'b1;
              m_hold[b]    = 0;
              m_long_ok[b] = 1'b1;
            end else begin
              e.rel[b] = 1'b1;
            end
          end
        end else begin
          m_run[b] = 0;
        end
      end
      if (ss != m_sw) begin
        if (m_sw_run > 0 && ss == m_sw_last) m_sw_run++;
        else begin
          m_sw_run  = 1;
          m_sw_last = ss;
        end
        if (m_sw_run == DB) begin
          m_sw     = ss;
          e.chg    = 1'b1;
          m_sw_run = 0;
        end
      end else begin
        m_sw_run = 0;
      end
    end
    e.lvl = m_lvl;
    e.sw  = m_sw;
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a registered output set; pop and compare.
  initial forever begin
    obs_t e, a;
    @(negedge clk);
    a.lvl = btn_level; a.prs = btn_press; a.rel = btn_release;
    a.lng = btn_long;  a.sw  = sw_out;    a.chg = sw_changed;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d actual=%h required=queued entry", cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, a, e);
      end
    end
    for (int b = 0; b < N_BTN; b++) begin
      if (btn_press[b])   begin press_cnt[b]++; press_cyc[b] = cyc; end
      if (btn_release[b]) begin rel_cnt[b]++;   rel_cyc[b]   = cyc; end
      if (btn_long[b])    begin long_cnt[b]++;  long_cyc[b]  = cyc; end
    end
    if (sw_changed) begin chg_cnt++; chg_cyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clr();
    for (int b = 0; b < N_BTN; b++) begin
      press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
    end
    chg_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    tick(3);
    chk("reset_btn_outs", int'(btn_level | btn_press | btn_release | btn_long), 0);
    chk("reset_sw_outs", int'({sw_out, sw_changed}), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean press and long press, then clean release
    clr(); t0 = cyc; btn_raw[0] = 1'b1; tick(30);
    chk("clean_press_count", press_cnt[0], 1);
    chk("clean_press_latency", press_cyc[0] - t0, 6);
    chk("clean_level", int'(btn_level[0]), 1);
    chk("long_count", long_cnt[0], 1);
    chk("long_after_press", long_cyc[0] - press_cyc[0], 19);
    btn_raw[0] = 1'b0; t0 = cyc; tick(10);
    chk("clean_release_latency", rel_cyc[0] - t0, 6);
    chk("clean_release_level", int'(btn_level[0]), 0);

    // Bounce 1,0,1,0 then hold
    clr();
    for (int i = 0; i < 4; i++) begin
      btn_raw[1] = ~btn_raw[1];
      tick(1);
    end
    t0 = cyc; btn_raw[1] = 1'b1; tick(12);
    chk("bounce_press_count", press_cnt[1], 1);
    chk("bounce_press_latency", press_cyc[1] - t0, 6);
    btn_raw[1] = 1'b0; tick(10);

    // Short glitch
    clr(); btn_raw[2] = 1'b1; tick(3); btn_raw[2] = 1'b0; tick(10);
    chk("glitch_press_count", press_cnt[2], 0);
    chk("glitch_level", int'(btn_level[2]), 0);

    // Release with a 2-cycle high blip
    clr(); btn_raw[3] = 1'b1; tick(10);
    btn_raw[3] = 1'b0; tick(1); btn_raw[3] = 1'b1; tick(2);
    btn_raw[3] = 1'b0; t0 = cyc; tick(12);
    chk("relbounce_press_count", press_cnt[3], 1);
    chk("relbounce_long_count", long_cnt[3], 0);
    chk("relbounce_release_count", rel_cnt[3], 1);
    chk("relbounce_release_latency", rel_cyc[3] - t0, 6);

    // Switch bus: clean change, then a mid-count flip
    clr(); t0 = cyc; sw_raw = 8'hA5; tick(10);
    chk("sw_changed_count", chg_cnt, 1);
    chk("sw_changed_latency", chg_cyc - t0, 6);
    chk("sw_value_a5", int'(sw_out), 'hA5);
    clr(); sw_raw = 8'h3C; tick(2); sw_raw = 8'hA4; t0 = cyc; tick(10);
    chk("sw_flip_changed_count", chg_cnt, 1);
    chk("sw_flip_latency", chg_cyc - t0, 6);
    chk("sw_value_a4", int'(sw_out), 'hA4);

    // Reset during PRESS_WAIT
    clr(); btn_raw[4] = 1'b1; tick(3);
    rst_n = 1'b0; #1;
    chk("reset_pw_outs", int'({btn_level, btn_press, btn_release, btn_long, sw_out, sw_changed}), 0);
    tick(2); rst_n = 1'b1; t0 = cyc; tick(10);
    chk("post_reset_press_count", press_cnt[4], 1);
    chk("post_reset_press_latency", press_cyc[4] - t0, 6);

    // Reset during PRESSED
    tick(5);
    rst_n = 1'b0; #1;
    chk("reset_pressed_outs", int'({btn_level, btn_press, btn_release, btn_long, sw_out, sw_changed}), 0);
    btn_raw[4] = 1'b0; tick(2); rst_n = 1'b1; tick(12);
    chk("reset_pressed_no_press", press_cnt[4], 1);
    chk("reset_pressed_no_release", rel_cnt[4], 0);
    chk("reset_pressed_no_long", long_cnt[4], 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N_BTN; b++) begin
        if ($urandom_range(0, 99) < 2 + 3 * b) btn_raw[b] = ~btn_raw[b];
      end
      if ($urandom_range(0, 99) < 4) sw_raw = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) < 2) begin
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
      end
      tick(1);
    end
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
